// File: rtl/fwd_hazard_pkg.sv
// Shared encodings for the forwarding / hazard unit: operand select
// codes and the stall FSM state type.
package fwd_hazard_pkg;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    localparam int WAIT_W = 3;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        LU_STALL = 2'd1,
        MEM_WAIT = 2'd2
    } hzState_t;

endpackage

// File: rtl/fwd_hazard_unit_fwd_match.sv
// Operand forward select for one EX source from the MEM/WB tags.
// Ports: src/srcUsed (EX source), mem*/wb* producer tags, sel (FWD_*).
module fwd_match #(
    parameter int REG_AW = 4
) (
    input  logic [REG_AW-1:0] src,
    input  logic              srcUsed,
    input  logic              memV,
    input  logic              memRw,
    input  logic              memMr,
    input  logic [REG_AW-1:0] memDst,
    input  logic              wbV,
    input  logic              wbRw,
    input  logic [REG_AW-1:0] wbDst,
    output logic [1:0]        sel
);
    import fwd_hazard_pkg::*;

    logic memHit;
    logic wbHit;

    // A load in MEM has no data yet, so it never feeds EX from MEM.
    assign memHit = srcUsed & memV & memRw & ~memMr
                  & (memDst != '0) & (memDst == src);
    assign wbHit  = srcUsed & wbV & wbRw
                  & (wbDst != '0) & (wbDst == src);

    always_comb begin
        sel = FWD_RF;
        if (memHit) begin
            sel = FWD_MEM;
        end else if (wbHit) begin
            sel = FWD_WB;
        end
    end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding and hazard control: tracks EX/MEM/WB tags, picks operand
// forwards, raises load-use bubbles and memory-latency freezes, and
// counts stall cycles. Inputs: ID tags, flush, ext_stall. Outputs:
// fwd_a/fwd_b, dmem_fwd, hold_fe, bubble_ex, freeze, stall_cnt.
module fwd_hazard_unit #(
    parameter int REG_AW  = 4,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              id_valid,
    input  logic [REG_AW-1:0] id_src1,
    input  logic [REG_AW-1:0] id_src2,
    input  logic              id_src1_used,
    input  logic              id_src2_used,
    input  logic [REG_AW-1:0] id_dst,
    input  logic              id_regwrite,
    input  logic              id_memread,
    input  logic              id_memwrite,
    input  logic              flush,
    input  logic              ext_stall,
    output logic [1:0]        fwd_a,
    output logic [1:0]        fwd_b,
    output logic              dmem_fwd,
    output logic              hold_fe,
    output logic              bubble_ex,
    output logic              freeze,
    output logic [CNT_W-1:0]  stall_cnt
);
    import fwd_hazard_pkg::*;

    logic              exV, exRw, exMr, exMw, exU1, exU2;
    logic [REG_AW-1:0] exDst, exS1, exS2;
    logic              memV, memRw, memMr, memMw;
    logic [REG_AW-1:0] memDst, memS2;
    logic              wbV, wbRw;
    logic [REG_AW-1:0] wbDst;

    hzState_t          state, stateNext;
    logic [WAIT_W-1:0] waitCnt, waitNext;
    logic [CNT_W-1:0]  stallCnt;

    logic luHit;
    logic loadEnter;
    logic exVNext;

    // Load in EX whose result a used ID source needs.
    assign luHit = id_valid & exV & exRw & exMr & (exDst != '0)
                 & ((id_src1_used & (exDst == id_src1))
                 |  (id_src2_used & (exDst == id_src2)));

    assign freeze    = ext_stall | (state == MEM_WAIT);
    assign loadEnter = ~freeze & exV & exMr;
    assign exVNext   = id_valid & ~flush & ~luHit;

    always_comb begin
        hold_fe   = 1'b0;
        bubble_ex = 1'b0;
        if (freeze) begin
            hold_fe = 1'b1;
        end else if (luHit) begin
            bubble_ex = 1'b1;
            hold_fe   = ~flush;
        end
    end

    fwd_match #(.REG_AW(REG_AW)) uMatchA (
        .src(exS1), .srcUsed(exU1),
        .memV(memV), .memRw(memRw), .memMr(memMr), .memDst(memDst),
        .wbV(wbV), .wbRw(wbRw), .wbDst(wbDst),
        .sel(fwd_a)
    );

    fwd_match #(.REG_AW(REG_AW)) uMatchB (
        .src(exS2), .srcUsed(exU2),
        .memV(memV), .memRw(memRw), .memMr(memMr), .memDst(memDst),
        .wbV(wbV), .wbRw(wbRw), .wbDst(wbDst),
        .sel(fwd_b)
    );

    assign dmem_fwd = memV & memMw & wbV & wbRw
                    & (wbDst != '0) & (wbDst == memS2);

    assign stall_cnt = stallCnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exV <= 1'b0; exRw <= 1'b0; exMr <= 1'b0; exMw <= 1'b0;
            exU1 <= 1'b0; exU2 <= 1'b0;
            exDst <= '0; exS1 <= '0; exS2 <= '0;
            memV <= 1'b0; memRw <= 1'b0; memMr <= 1'b0; memMw <= 1'b0;
            memDst <= '0; memS2 <= '0;
            wbV <= 1'b0; wbRw <= 1'b0; wbDst <= '0;
        end else if (!freeze) begin
            exV   <= exVNext;
            exDst <= id_dst;
            exRw  <= id_regwrite;
            exMr  <= id_memread;
            exMw  <= id_memwrite;
            exS1  <= id_src1;
            exS2  <= id_src2;
            // Bubbles carry no used sources, so they never forward.
            exU1  <= id_src1_used & exVNext;
            exU2  <= id_src2_used & exVNext;
            memV   <= exV;
            memDst <= exDst;
            memRw  <= exRw;
            memMr  <= exMr;
            memMw  <= exMw;
            memS2  <= exS2;
            wbV   <= memV;
            wbDst <= memDst;
            wbRw  <= memRw;
        end
    end

    always_comb begin
        stateNext = state;
        waitNext  = waitCnt;
        unique case (state)
            RUN: begin
                if (loadEnter && (MEM_LAT > 1)) begin
                    stateNext = MEM_WAIT;
                    waitNext  = WAIT_W'(MEM_LAT - 1);
                end else if (!freeze && luHit && !flush) begin
                    stateNext = LU_STALL;
                end
            end
            LU_STALL: begin
                stateNext = RUN;
            end
            MEM_WAIT: begin
                if (!ext_stall) begin
                    waitNext = waitCnt - WAIT_W'(1);
                    if (waitCnt == WAIT_W'(1)) begin
                        stateNext = RUN;
                    end
                end
            end
            default: begin
                stateNext = RUN;
                waitNext  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            waitCnt <= '0;
        end else begin
            state   <= stateNext;
            waitCnt <= waitNext;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stallCnt <= '0;
        end else if (hold_fe && (stallCnt != '1)) begin
            stallCnt <= stallCnt + CNT_W'(1);
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two instances (load latency 1
// and 3) driven by small programs and a pipeline-level reference model.
module tb_fwd_hazard_unit;

    localparam int AW = 4;
    localparam int CW = 6;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    typedef struct packed {
        logic          valid;
        logic [AW-1:0] s1;
        logic [AW-1:0] s2;
        logic          u1;
        logic          u2;
        logic [AW-1:0] dst;
        logic          rw;
        logic          mr;
        logic          mw;
        logic          flush;
        logic          ext;
    } in_t;

    in_t           inp [2];
    logic [1:0]    fa  [2];
    logic [1:0]    fb  [2];
    logic          dm  [2];
    logic          hf  [2];
    logic          bx  [2];
    logic          fz  [2];
    logic [CW-1:0] sc  [2];

    for (genvar g = 0; g < 2; g++) begin : gDut
        fwd_hazard_unit #(
            .REG_AW(AW), .MEM_LAT(g == 0 ? 1 : 3), .CNT_W(CW)
        ) dut (
            .clk(clk), .rst(rst),
            .id_valid(inp[g].valid),
            .id_src1(inp[g].s1), .id_src2(inp[g].s2),
            .id_src1_used(inp[g].u1), .id_src2_used(inp[g].u2),
            .id_dst(inp[g].dst),
            .id_regwrite(inp[g].rw), .id_memread(inp[g].mr),
            .id_memwrite(inp[g].mw),
            .flush(inp[g].flush), .ext_stall(inp[g].ext),
            .fwd_a(fa[g]), .fwd_b(fb[g]), .dmem_fwd(dm[g]),
            .hold_fe(hf[g]), .bubble_ex(bx[g]), .freeze(fz[g]),
            .stall_cnt(sc[g])
        );
    end

    typedef struct {
        bit v;
        int dst;
        bit rw;
        bit mr;
        bit mw;
        int s1;
        int s2;
        bit u1;
        bit u2;
        bit flush;
    } ins_t;

    typedef struct packed {
        logic [1:0]    fa;
        logic [1:0]    fb;
        logic          dm;
        logic          hf;
        logic          bx;
        logic          fz;
        logic [CW-1:0] sc;
    } exp_t;

    ins_t mEx [2];
    ins_t mMem [2];
    ins_t mWb [2];
    int   mWait [2];
    int   mCnt [2];
    bit   lastHold [2];
    exp_t q [2][$];
    ins_t prog [$];

    int checks = 0;
    int errors = 0;

    function automatic int lat(int k);
        return (k == 0) ? 1 : 3;
    endfunction

    function automatic bit prod(ins_t p, int src, bit used);
        return used && p.v && p.rw && p.dst != 0 && p.dst == src;
    endfunction

    function automatic logic [1:0] sel(int k, int src, bit used);
        if (prod(mMem[k], src, used) && !mMem[k].mr) return 2'b10;
        if (prod(mWb[k], src, used)) return 2'b01;
        return 2'b00;
    endfunction

    function automatic ins_t mk(int dst, int s1, bit u1, int s2, bit u2,
                                bit rw, bit mr, bit mw, bit fl);
        ins_t r;
        r.v = 1; r.dst = dst; r.s1 = s1; r.u1 = u1; r.s2 = s2; r.u2 = u2;
        r.rw = rw; r.mr = mr; r.mw = mw; r.flush = fl;
        return r;
    endfunction

    function automatic in_t toIn(ins_t r);
        in_t x;
        x.valid = r.v; x.s1 = AW'(r.s1); x.s2 = AW'(r.s2);
        x.u1 = r.u1; x.u2 = r.u2; x.dst = AW'(r.dst);
        x.rw = r.rw; x.mr = r.mr; x.mw = r.mw;
        x.flush = r.flush; x.ext = 1'b0;
        return x;
    endfunction

    task automatic modelReset(int k);
        mEx[k] = '{default: 0};
        mMem[k] = '{default: 0};
        mWb[k] = '{default: 0};
        mWait[k] = 0;
        mCnt[k] = 0;
    endtask

    // One clock: predict outputs from model state + current inputs,
    // queue them, then step the model across the edge.
    task automatic tick();
        ins_t nEx [2];
        ins_t nMem [2];
        ins_t nWb [2];
        int   nWait [2];
        int   nCnt [2];
        for (int k = 0; k < 2; k++) begin
            ins_t id;
            ins_t empty;
            exp_t e;
            bit   frozen, lu, hold;
            empty = '{default: 0};
            if (rst) modelReset(k);
            id = empty;
            id.v = inp[k].valid; id.dst = int'(inp[k].dst);
            id.s1 = int'(inp[k].s1); id.s2 = int'(inp[k].s2);
            id.u1 = inp[k].u1; id.u2 = inp[k].u2;
            id.rw = inp[k].rw; id.mr = inp[k].mr; id.mw = inp[k].mw;
            frozen = inp[k].ext || mWait[k] > 0;
            lu = id.v && mEx[k].mr && (prod(mEx[k], id.s1, id.u1)
                 || prod(mEx[k], id.s2, id.u2));
            hold = frozen || (lu && !inp[k].flush);
            e.fa = sel(k, mEx[k].s1, mEx[k].u1);
            e.fb = sel(k, mEx[k].s2, mEx[k].u2);
            e.dm = mMem[k].v && mMem[k].mw && prod(mWb[k], mMem[k].s2, 1);
            e.hf = hold;
            e.bx = !frozen && lu;
            e.fz = frozen;
            e.sc = CW'(mCnt[k]);
            q[k].push_back(e);
            lastHold[k] = hold;
            if (!frozen) begin
                nWb[k] = mMem[k];
                nMem[k] = mEx[k];
                nEx[k] = (id.v && !inp[k].flush && !lu) ? id : empty;
                nWait[k] = (mEx[k].v && mEx[k].mr && lat(k) > 1)
                         ? lat(k) - 1 : 0;
            end else begin
                nWb[k] = mWb[k];
                nMem[k] = mMem[k];
                nEx[k] = mEx[k];
                nWait[k] = (mWait[k] > 0 && !inp[k].ext)
                         ? mWait[k] - 1 : mWait[k];
            end
            nCnt[k] = (hold && mCnt[k] < (1 << CW) - 1)
                    ? mCnt[k] + 1 : mCnt[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                modelReset(k);
            end else begin
                mEx[k] = nEx[k]; mMem[k] = nMem[k]; mWb[k] = nWb[k];
                mWait[k] = nWait[k]; mCnt[k] = nCnt[k];
            end
        end
        #1;
    endtask

    always @(negedge clk) begin
        exp_t e;
        for (int k = 0; k < 2; k++) begin
            if (q[k].size() > 0) begin
                e = q[k].pop_front();
                checks++;
                if (fa[k] !== e.fa || fb[k] !== e.fb) begin
                    errors++;
                    $display("FAIL dut%0d fwd: got a=%b b=%b want a=%b b=%b",
                             k, fa[k], fb[k], e.fa, e.fb);
                end
                checks++;
                if ({dm[k], hf[k], bx[k], fz[k]} !==
                    {e.dm, e.hf, e.bx, e.fz}) begin
                    errors++;
                    $display("FAIL dut%0d ctrl dm/hf/bx/fz: got %b%b%b%b want %b%b%b%b",
                             k, dm[k], hf[k], bx[k], fz[k],
                             e.dm, e.hf, e.bx, e.fz);
                end
                checks++;
                if (sc[k] !== e.sc) begin
                    errors++;
                    $display("FAIL dut%0d stall_cnt: got %0d want %0d",
                             k, sc[k], e.sc);
                end
            end
        end
    end

    task automatic chk(string nm, int got, int want);
        checks++;
        if (got != want) begin
            errors++;
            $display("FAIL %s: got %0d want %0d", nm, got, want);
        end
    endtask

    task automatic idleAll();
        inp[0] = '0;
        inp[1] = '0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        idleAll();
        tick();
        tick();
        rst = 1'b0;
    endtask

    // Feed prog into ID of instance k, holding the head while the
    // model says the front end is held; then drain idle cycles.
    task automatic runProg(int k, bit rnd, int drain);
        int guard = 0;
        int left = drain;
        while ((prog.size() > 0 || left > 0) && guard < 2000) begin
            guard++;
            if (prog.size() > 0) inp[k] = toIn(prog[0]);
            else inp[k] = '0;
            inp[k].ext = rnd && ($urandom_range(0, 7) == 0);
            tick();
            if (prog.size() > 0) begin
                if (!lastHold[k]) void'(prog.pop_front());
            end else begin
                left--;
            end
        end
        if (guard >= 2000) begin
            checks++;
            errors++;
            $display("FAIL runProg dut%0d: cycle budget expired", k);
        end
        inp[k] = '0;
    endtask

    initial begin
        rst = 1'b1;
        idleAll();
        for (int k = 0; k < 2; k++) modelReset(k);
        @(posedge clk);
        #1;
        doReset();
        #1;
        chk("reset fwd_a", int'(fa[0]), 0);
        chk("reset freeze", int'(fz[1]), 0);
        chk("reset stall_cnt", int'(sc[1]), 0);

        // ADD r3 -> ADD r4,r3,r3 ; ADD r0 -> ADD r5,r0,r0
        prog.push_back(mk(3, 1, 1, 2, 1, 1, 0, 0, 0));
        prog.push_back(mk(4, 3, 1, 3, 1, 1, 0, 0, 0));
        prog.push_back(mk(0, 1, 1, 2, 1, 1, 0, 0, 0));
        prog.push_back(mk(5, 0, 1, 0, 1, 1, 0, 0, 0));
        runProg(0, 0, 5);

        // load-use, latency 1
        doReset();
        prog.push_back(mk(5, 1, 1, 0, 0, 1, 1, 0, 0));
        prog.push_back(mk(6, 5, 1, 1, 1, 1, 0, 0, 0));
        runProg(0, 0, 5);
        chk("lu lat1 stall_cnt", int'(sc[0]), 1);

        // load-use, latency 3
        doReset();
        prog.push_back(mk(5, 1, 1, 0, 0, 1, 1, 0, 0));
        prog.push_back(mk(6, 5, 1, 1, 1, 1, 0, 0, 0));
        runProg(1, 0, 6);
        chk("lu lat3 stall_cnt", int'(sc[1]), 3);

        // ADD r2 then SW r2 data
        doReset();
        prog.push_back(mk(2, 1, 1, 3, 1, 1, 0, 0, 0));
        prog.push_back(mk(0, 7, 1, 2, 1, 0, 0, 1, 0));
        runProg(0, 0, 5);

        // load-use with flush
        doReset();
        inp[0] = toIn(mk(5, 1, 1, 0, 0, 1, 1, 0, 0));
        tick();
        inp[0] = toIn(mk(6, 5, 1, 1, 1, 1, 0, 0, 1));
        #1;
        chk("flush bubble_ex", int'(bx[0]), 1);
        chk("flush hold_fe", int'(hf[0]), 0);
        tick();
        inp[0] = '0;
        #1;
        chk("flush no LU_STALL hold", int'(hf[0]), 0);
        tick();
        tick();
        chk("flush stall_cnt", int'(sc[0]), 0);

        // reset during MEM_WAIT
        doReset();
        inp[1] = toIn(mk(5, 1, 1, 0, 0, 1, 1, 0, 0));
        tick();
        inp[1] = toIn(mk(6, 5, 1, 1, 1, 1, 0, 0, 0));
        tick();
        chk("mem_wait freeze", int'(fz[1]), 1);
        rst = 1'b1;
        inp[1] = '0;
        tick();
        rst = 1'b0;
        tick();
        chk("post-rst freeze", int'(fz[1]), 0);
        chk("post-rst stall_cnt", int'(sc[1]), 0);
        chk("post-rst fwd_a", int'(fa[1]), 0);

        // randomized programs with flush and external stalls
        for (int k = 0; k < 2; k++) begin
            doReset();
            for (int i = 0; i < 200; i++) begin
                int t = $urandom_range(0, 3);
                prog.push_back(mk($urandom_range(0, 7),
                                  $urandom_range(0, 7), $urandom_range(0, 3) != 0,
                                  $urandom_range(0, 7), $urandom_range(0, 1) == 1,
                                  t != 1, t == 0, t == 1,
                                  $urandom_range(0, 9) == 0));
            end
            runProg(k, 1, 6);
        end

        repeat (2) @(negedge clk);
        #1;
        for (int k = 0; k < 2; k++) begin
            checks++;
            if (q[k].size() != 0) begin
                errors++;
                $display("FAIL scoreboard dut%0d: %0d entries left, want 0",
                         k, q[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/fwd_hazard_unit.md
FWD_HAZARD_UNIT -- requirements
Module: fwd_hazard_unit

Interface
REQ-001 Parameter REG_AW, default 4: register-index width; register 0 is hardwired zero.
REQ-002 Parameter MEM_LAT, default 1, legal range 1..4: data-memory load latency in cycles.
REQ-003 Parameter CNT_W, default 16: stall performance counter width.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  asynchronous, active-high reset.
REQ-006 id_valid  in  1  ID stage holds a real instruction.
REQ-007 id_src1, id_src2  in  REG_AW  ID source register indices.
REQ-008 id_src1_used, id_src2_used  in  1  source actually read (LLB/LHB use src1 only).
REQ-009 id_dst  in  REG_AW  ID destination index.
REQ-010 id_regwrite, id_memread, id_memwrite  in  1  ID control bits.
REQ-011 flush  in  1  squash the ID instruction (branch taken).
REQ-012 ext_stall  in  1  external freeze request.
REQ-013 fwd_a, fwd_b  out  2  EX operand select: 00 regfile, 01 WB, 10 MEM.
REQ-014 dmem_fwd  out  1  MEM-to-MEM store-data forward from WB.
REQ-015 hold_fe  out  1  hold PC and IF/ID.
REQ-016 bubble_ex  out  1  load a bubble into ID/EX.
REQ-017 freeze  out  1  hold every pipeline register.
REQ-018 stall_cnt  out  CNT_W  count of cycles with hold_fe or freeze asserted.

Function
REQ-019 Internal tag pipeline: EX {v,dst,rw,mr,mw,s1,s2,u1,u2}, MEM {v,dst,rw,mr,mw,s2}, WB {v,dst,rw}; advances ID->EX->MEM->WB each cycle freeze=0.
REQ-020 When bubble_ex=1 and freeze=0, EX.v SHALL load 0 while MEM and WB still advance.
REQ-021 A producer matches a source only if v=1, rw=1, dst!=0, dst==src, and the source's used bit=1.
REQ-022 fwd_a/fwd_b = 10 on a match with MEM where MEM.mr=0; otherwise 01 on a match with WB; otherwise 00; MEM has priority over WB. All combinational from registered tags.
REQ-023 Load-use: ID valid, not flushed, with a used source matching EX where EX.mr=1 -> hold_fe=1, bubble_ex=1 for exactly one cycle.
REQ-024 dmem_fwd=1 when MEM.v, MEM.mw, WB.v, WB.rw, WB.dst!=0, WB.dst==MEM.s2.
REQ-025 FSM states RUN, LU_STALL, MEM_WAIT; RUN->LU_STALL on load-use; LU_STALL->RUN next cycle.
REQ-026 On a load entering MEM with MEM_LAT>1: RUN->MEM_WAIT, wait counter=MEM_LAT-1; freeze=1 while counter!=0; counter decrements each cycle; return to RUN at 0. MEM_LAT=1 never enters MEM_WAIT.
REQ-027 freeze = ext_stall OR (state==MEM_WAIT); during freeze no tag moves, hold_fe=1, bubble_ex=0, wait counter still decrements unless ext_stall=1.
REQ-028 Priority: ext_stall > MEM_WAIT > flush > load-use; flush with load-use gives bubble_ex=1, hold_fe=0, no LU_STALL.
REQ-029 stall_cnt saturates at all-ones.
REQ-030 Forward selects SHALL be valid during freeze, reflecting held tags.

Reset
REQ-031 rst SHALL clear all tag valids, state=RUN, wait counter=0, stall_cnt=0; outputs then 00/00/0/0/0/0/0.
REQ-032 Reset asserted mid-MEM_WAIT or mid-LU_STALL SHALL abort immediately; no residual stall after release.

Structure
REQ-033 Shared package holds fwd select encodings (FWD_RF, FWD_WB, FWD_MEM) and FSM state enum.
REQ-034 One sub-module, fwd_match, computing a single source's select from MEM/WB tags; instantiated twice.

Verification
REQ-035 ADD r3 then ADD r4,r3,r3 back-to-back -> fwd_a=fwd_b=10 in consumer EX cycle; r0 dst -> 00.
REQ-036 LW r5 then ADD r6,r5,r1, MEM_LAT=1 -> one cycle hold_fe=bubble_ex=1, then fwd_a=01; stall_cnt=1.
REQ-037 Same with MEM_LAT=3 -> 1 LU cycle plus 2 freeze cycles, stall_cnt=3, then fwd_a=01.
REQ-038 ADD r2 then SW r2 (data reg) one instruction later -> dmem_fwd=1 with SW in MEM.
REQ-039 Load-use coinciding with flush=1 -> bubble_ex=1, hold_fe=0, state stays RUN.
REQ-040 rst pulsed during MEM_WAIT -> freeze=0 next cycle, stall_cnt=0, all selects 00.
